vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 38 +++
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and the pixel source.
// ReqX/ReqY/req_valid exist only when VGA_TIMING_PREFETCH_EN is defined.
interface vga_timing_gen_if #(
  parameter int CX_W = 11,
  parameter int CY_W = 10
);
  logic            pix_ce;
  logic            eof_clr;
  logic            HS;
  logic            VS;
  logic            BLANK_n;
  logic [CX_W-1:0] CoorX;
  logic [CY_W-1:0] CoorY;
  logic            line_start;
  logic            frame_start;
  logic            eof_flag;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [CX_W-1:0] ReqX;
  logic [CY_W-1:0] ReqY;
  logic            req_valid;
`endif

  modport master (
    input  pix_ce, eof_clr,
`ifdef VGA_TIMING_PREFETCH_EN
    output ReqX, ReqY, req_valid,
`endif
    output HS, VS, BLANK_n, CoorX, CoorY, line_start, frame_start, eof_flag
  );

  modport slave (
    output pix_ce, eof_clr,
`ifdef VGA_TIMING_PREFETCH_EN
    input  ReqX, ReqY, req_valid,
`endif
    input  HS, VS, BLANK_n, CoorX, CoorY, line_start, frame_start, eof_flag
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, coordinates and frame strobes.
// Define VGA_TIMING_PREFETCH_EN to add one-cycle-early ReqX/ReqY/req_valid outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CX_W     = 11,
  parameter int CY_W     = 10
) (
  input  logic               vga_clk,
  input  logic               reset,
  vga_timing_gen_if.master   vga
);
  localparam int H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  if (H_TOT - 1 >= (1 << CX_W)) begin : g_cx_too_narrow
    $error("vga_timing_gen: CX_W cannot hold H_TOT-1");
  end
  if (V_TOT - 1 >= (1 << CY_W)) begin : g_cy_too_narrow
    $error("vga_timing_gen: CY_W cannot hold V_TOT-1");
  end

  localparam logic [CX_W-1:0] H_SYNC_C   = CX_W'(H_SYNC);
  localparam logic [CX_W-1:0] H_VIS_LO   = CX_W'(H_SYNC + H_BACK);
  localparam logic [CX_W-1:0] H_VIS_HI   = CX_W'(H_TOT - H_FRONT);
  localparam logic [CX_W-1:0] H_LAST     = CX_W'(H_TOT - 1);
  localparam logic [CX_W-1:0] H_ACT_C    = CX_W'(H_ACTIVE);
  localparam logic [CX_W-1:0] H_ACT_LAST = CX_W'(H_ACTIVE - 1);
  localparam logic [CY_W-1:0] V_SYNC_C   = CY_W'(V_SYNC);
  localparam logic [CY_W-1:0] V_VIS_LO   = CY_W'(V_SYNC + V_BACK);
  localparam logic [CY_W-1:0] V_VIS_HI   = CY_W'(V_TOT - V_FRONT);
  localparam logic [CY_W-1:0] V_LAST     = CY_W'(V_TOT - 1);
  localparam logic [CY_W-1:0] V_ACT_C    = CY_W'(V_ACTIVE);
  localparam logic [CY_W-1:0] V_ACT_LAST = CY_W'(V_ACTIVE - 1);
  localparam logic            HS_ON      = 1'(HS_POL);
  localparam logic            VS_ON      = 1'(VS_POL);

  typedef struct packed {
    logic            hs;
    logic            vs;
    logic            blank_n;
    logic [CX_W-1:0] x;
    logic [CY_W-1:0] y;
    logic            line_start;
    logic            frame_start;
  } dec_t;

  localparam dec_t DEC_RST = '{hs: ~HS_ON, vs: ~VS_ON, blank_n: 1'b0, x: H_ACT_C,
                               y: V_ACT_C, line_start: 1'b0, frame_start: 1'b0};

  // Returns {visible, coordinate}; the coordinate parks at H_ACTIVE when not visible.
  function automatic logic [CX_W:0] h_coord(input logic [CX_W-1:0] h);
    logic vis;
    vis = (h >= H_VIS_LO) && (h < H_VIS_HI);
    return {vis, vis ? h - H_VIS_LO : H_ACT_C};
  endfunction

  function automatic logic [CY_W:0] v_coord(input logic [CY_W-1:0] v);
    logic vis;
    vis = (v >= V_VIS_LO) && (v < V_VIS_HI);
    return {vis, vis ? v - V_VIS_LO : V_ACT_C};
  endfunction

  function automatic dec_t decode(input logic [CX_W-1:0] h, input logic [CY_W-1:0] v);
    dec_t            d;
    logic [CX_W:0]   hc;
    logic [CY_W:0]   vc;
    hc            = h_coord(h);
    vc            = v_coord(v);
    d.hs          = (h < H_SYNC_C) ? HS_ON : ~HS_ON;
    d.vs          = (v < V_SYNC_C) ? VS_ON : ~VS_ON;
    d.blank_n     = hc[CX_W] & vc[CY_W];
    d.x           = hc[CX_W-1:0];
    d.y           = vc[CY_W-1:0];
    d.line_start  = (h == '0);
    d.frame_start = (h == '0) && (v == '0);
    return d;
  endfunction

  logic [CX_W-1:0] h_cnt_q, h_cnt_d;
  logic [CY_W-1:0] v_cnt_q, v_cnt_d;
  dec_t            dec_q, dec_d;
  logic            eof_flag_q, eof_flag_d;
  logic            h_wrap;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    h_wrap     = (h_cnt_q == H_LAST);
    h_cnt_d    = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d    = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    dec_d      = decode(h_cnt_q, v_cnt_q);
    // Set outranks a simultaneous clear.
    eof_flag_d = (vga.pix_ce && dec_d.x == H_ACT_LAST && dec_d.y == V_ACT_LAST)
                 | (eof_flag_q & ~vga.eof_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      dec_q      <= DEC_RST;
      eof_flag_q <= 1'b0;
    end else begin
      if (vga.pix_ce) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        dec_q   <= dec_d;
      end
      eof_flag_q <= eof_flag_d;
    end
  end

  assign vga.HS          = dec_q.hs;
  assign vga.VS          = dec_q.vs;
  assign vga.BLANK_n     = dec_q.blank_n;
  assign vga.CoorX       = dec_q.x;
  assign vga.CoorY       = dec_q.y;
  assign vga.line_start  = dec_q.line_start;
  assign vga.frame_start = dec_q.frame_start;
  assign vga.eof_flag    = eof_flag_q;

`ifdef VGA_TIMING_PREFETCH_EN
  // Decoding the next counter values gives what CoorX/CoorY/BLANK_n show one enabled edge later.
  logic [CX_W:0] req_h_d, req_h_q;
  logic [CY_W:0] req_v_d, req_v_q;

  always_comb begin
    req_h_d = h_coord(h_cnt_d);
    req_v_d = v_coord(h_wrap ? v_cnt_d : v_cnt_q);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      req_h_q <= {1'b0, H_ACT_C};
      req_v_q <= {1'b0, V_ACT_C};
    end else if (vga.pix_ce) begin
      req_h_q <= req_h_d;
      req_v_q <= req_v_d;
    end
  end

  assign vga.ReqX      = req_h_q[CX_W-1:0];
  assign vga.ReqY      = req_v_q[CY_W-1:0];
  assign vga.req_valid = req_h_q[CX_W] & req_v_q[CY_W];
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 12x7 raster (8x4 visible, positive sync).
module tb_vga_timing_gen;
  localparam int CX_W = 4;
  localparam int CY_W = 3;

  typedef struct packed {
    logic            hs;
    logic            vs;
    logic            blank_n;
    logic [CX_W-1:0] x;
    logic [CY_W-1:0] y;
    logic            ls;
    logic            fs;
    logic            eof;
`ifdef VGA_TIMING_PREFETCH_EN
    logic [CX_W-1:0] rx;
    logic [CY_W-1:0] ry;
    logic            rv;
`endif
  } obs_t;

  logic vga_clk = 1'b0;
  logic reset;
  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if #(.CX_W(CX_W), .CY_W(CY_W)) vif ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1),   .VS_POL(1),  .CX_W(CX_W), .CY_W(CY_W)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .vga     (vif)
  );

  // Hand-derived line/frame patterns: line = sync(2) back(1) active(8) front(1);
  // frame = sync(1) back(1) active(4) front(1).
  int hs_tab [12] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int x_tab  [12] = '{8, 8, 8, 0, 1, 2, 3, 4, 5, 6, 7, 8};
  int vs_tab [7]  = '{1, 0, 0, 0, 0, 0, 0};
  int y_tab  [7]  = '{4, 4, 0, 1, 2, 3, 4};

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;

  // Reference state: position the DUT counters should hold, plus expected outputs.
  int   m_h, m_v;
  obs_t m_out;
  logic m_eof;
  logic [CX_W-1:0] m_rx;
  logic [CY_W-1:0] m_ry;
  logic m_rv;

  function automatic obs_t pix(input int h, input int v);
    obs_t o;
    o         = '0;
    o.hs      = 1'(hs_tab[h]);
    o.vs      = 1'(vs_tab[v]);
    o.x       = CX_W'(x_tab[h]);
    o.y       = CY_W'(y_tab[v]);
    o.blank_n = (x_tab[h] != 8) && (y_tab[v] != 4);
    o.ls      = (h == 0);
    o.fs      = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a         = '0;
    a.hs      = vif.HS;
    a.vs      = vif.VS;
    a.blank_n = vif.BLANK_n;
    a.x       = vif.CoorX;
    a.y       = vif.CoorY;
    a.ls      = vif.line_start;
    a.fs      = vif.frame_start;
    a.eof     = vif.eof_flag;
`ifdef VGA_TIMING_PREFETCH_EN
    a.rx      = vif.ReqX;
    a.ry      = vif.ReqY;
    a.rv      = vif.req_valid;
`endif
    return a;
  endfunction

  // Drives one cycle of inputs and queues the outputs expected after the next rising edge.
  task automatic step(input logic rst, input logic ce, input logic clr);
    obs_t e;
    obs_t nxt;
    logic set;
    @(negedge vga_clk);
    reset       = rst;
    vif.pix_ce  = ce;
    vif.eof_clr = clr;
    if (rst) begin
      m_h   = 0;
      m_v   = 0;
      m_out = '0;
      m_out.x = CX_W'(8);
      m_out.y = CY_W'(4);
      m_eof = 1'b0;
      m_rx  = CX_W'(8);
      m_ry  = CY_W'(4);
      m_rv  = 1'b0;
    end else if (ce) begin
      set   = (m_h == 10) && (m_v == 5);
      m_out = pix(m_h, m_v);
      m_h   = m_h + 1;
      if (m_h == 12) begin
        m_h = 0;
        m_v = (m_v == 6) ? 0 : m_v + 1;
      end
      nxt  = pix(m_h, m_v);
      m_rx = nxt.x;
      m_ry = nxt.y;
      m_rv = nxt.blank_n;
      if (set) m_eof = 1'b1;
      else if (clr) m_eof = 1'b0;
    end else if (clr) begin
      m_eof = 1'b0;
    end
    e     = m_out;
    e.eof = m_eof;
`ifdef VGA_TIMING_PREFETCH_EN
    e.rx  = m_rx;
    e.ry  = m_ry;
    e.rv  = m_rv;
`endif
    exp_q.push_back(e);
    n_push++;
  endtask

  // Monitor: one registered output set per clock, compared against the queue head.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge vga_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = sample();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got %h expected %h (h=%0d v=%0d)", $time, a, e, m_h, m_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    vif.pix_ce  = 1'b0;
    vif.eof_clr = 1'b0;
    m_h = 0; m_v = 0; m_out = '0; m_eof = 1'b0;
    m_rx = '0; m_ry = '0; m_rv = 1'b0;

    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Two frames free-running; clear once mid-frame, then collide clear with the set edge.
    for (int i = 0; i < 170; i++)
      step(1'b0, 1'b1, (i == 100) || (i >= 84 && m_h == 10 && m_v == 5));

    // Enable at half rate; clear while enable is low.
    for (int i = 0; i < 170; i++)
      step(1'b0, (i % 2) == 0, i == 41);

    // Mid-frame reset, then release with enable high.
    while (!(m_h == 5 && m_v == 3)) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 90; i++) step(1'b0, 1'b1, 1'b0);

    // Reset with enable low, idle, then resume: frame_start on first enabled edge.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);

    // Irregular enable and clear pattern.
    for (int i = 0; i < 200; i++)
      step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);

    @(negedge vga_clk);
    repeat (2) @(posedge vga_clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || checks != n_push + 1) begin
      errors++;
      $display("FAIL drain: got %0d compared, %0d left; expected %0d compared, 0 left",
               checks - 1, exp_q.size(), n_push);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
